// File: rtl/arbiter_pkg.sv
// Shared arbiter definitions: arbitration mode constants, FSM state encoding
// and width helpers reused by every arbiter in the codebase.
package arbiter_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int hold_width(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational winner selection: first masked request found when searching
// upward from start and wrapping modulo N. Fixed priority drives start = 0.
module rr_select
    import arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = id_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] start,
    input  logic [N-1:0]   mask,
    output logic [N-1:0]   winner,
    output logic [IDW-1:0] winner_id,
    output logic           found
);

    logic [2*N-1:0] rot;
    int             offset;
    int             sum;

    always_comb begin
        // Doubling the vector turns the wrap-around search into a plain shift.
        rot       = {req & mask, req & mask} >> start;
        found     = 1'b0;
        offset    = 0;
        sum       = 0;
        winner    = '0;
        winner_id = '0;
        for (int j = 0; j < N; j++) begin
            if (!found && rot[j]) begin
                found  = 1'b1;
                offset = j;
            end
        end
        if (found) begin
            sum = int'(start) + offset;
            if (sum >= N) begin
                sum = sum - N;
            end
            winner_id = IDW'(sum);
            winner    = {{(N-1){1'b0}}, 1'b1} << winner_id;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// N-requester arbiter with locked, registered one-hot grant, fixed-priority or
// round-robin selection and an optional per-tenure hold limit.
module rr_arbiter
    import arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int MODE     = 1,
    parameter int MAX_HOLD = 0,
    localparam int IDW     = id_width(N),
    localparam int HW      = hold_width(MAX_HOLD)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id
);

    arb_state_t     state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;

    logic [N-1:0]   sel_winner;
    logic [IDW-1:0] sel_id;
    logic           sel_found;
    logic [IDW-1:0] sel_start;
    logic           owner_keeps;
    logic           others_wait;
    logic           revoke;
    logic           arbitrate;
    int             ptr_nxt;

    assign sel_start = (MODE == ARB_RR) ? ptr_q : '0;

    // Masking with ~grant_q excludes the current owner; it is all ones in IDLE.
    rr_select #(.N(N), .IDW(IDW)) u_select (
        .req       (req),
        .start     (sel_start),
        .mask      (~grant_q),
        .winner    (sel_winner),
        .winner_id (sel_id),
        .found     (sel_found)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_id_d  = grant_id_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        ptr_nxt     = int'(sel_id) + 1;
        owner_keeps = |(req & grant_q);
        others_wait = |(req & ~grant_q);
        revoke      = (MAX_HOLD > 0) && (hold_cnt_q == HW'(MAX_HOLD)) && others_wait;

        case (state_q)
            ST_IDLE:  arbitrate = 1'b1;
            ST_OWNED: arbitrate = !owner_keeps || revoke;
            default:  arbitrate = 1'b1;
        endcase

        if (arbitrate) begin
            if (sel_found) begin
                state_d    = ST_OWNED;
                grant_d    = sel_winner;
                grant_id_d = sel_id;
                hold_cnt_d = HW'(1);
                ptr_d      = (ptr_nxt >= N) ? '0 : IDW'(ptr_nxt);
            end else begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                grant_id_d = '0;
                hold_cnt_d = '0;
            end
        end else if ((MAX_HOLD > 0) && (hold_cnt_q != HW'(MAX_HOLD))) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // grant_valid qualifies grant/grant_id; there is no ready: a requester
    // consumes its grant simply by keeping req high.
    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = (state_q == ST_OWNED);

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: round-robin, fixed-priority and hold-limited
// instances driven from one clock/reset, plus a constrained random run.
module tb_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req_rr, req_fp, req_hd;
    logic [3:0] grant_rr, grant_fp, grant_hd;
    logic       valid_rr, valid_fp, valid_hd;
    logic [1:0] id_rr, id_fp, id_hd;

    int n_total;
    int n_bad;

    logic [3:0] exp_q[$];
    logic [1:0] exp_id_q[$];

    rr_arbiter #(.N(4), .MODE(1), .MAX_HOLD(0)) u_rr (
        .clk(clk), .reset(reset), .req(req_rr),
        .grant(grant_rr), .grant_valid(valid_rr), .grant_id(id_rr)
    );

    rr_arbiter #(.N(4), .MODE(0), .MAX_HOLD(0)) u_fp (
        .clk(clk), .reset(reset), .req(req_fp),
        .grant(grant_fp), .grant_valid(valid_fp), .grant_id(id_fp)
    );

    rr_arbiter #(.N(4), .MODE(1), .MAX_HOLD(3)) u_hd (
        .clk(clk), .reset(reset), .req(req_hd),
        .grant(grant_hd), .grant_valid(valid_hd), .grant_id(id_hd)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rr(input string tag, input logic [3:0] g, input logic [1:0] id);
        check_eq({tag, "_grant"}, 32'(grant_rr), 32'(g));
        check_eq({tag, "_id"}, 32'(id_rr), 32'(id));
        check_eq({tag, "_valid"}, 32'(valid_rr), 32'(g != 4'b0000));
    endtask

    logic [3:0] drop_mask;
    logic [3:0] req_prev;
    logic [3:0] g_prev;
    logic [1:0] exp_id;
    int         own_cnt[4];
    int         wait_cnt[4];

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        req_rr  = '0;
        req_fp  = '0;
        req_hd  = '0;
        tick();
        tick();
        check_rr("rst", 4'b0000, 2'd0);
        check_eq("rst_fp_valid", 32'(valid_fp), 32'd0);
        check_eq("rst_hd_grant", 32'(grant_hd), 32'd0);
        reset = 1'b0;

        // Round-robin rotation, each owner drops req for one cycle
        req_rr = 4'b1111;
        tick();
        check_rr("rr_first", 4'b0001, 2'd0);
        tick();
        check_rr("rr_lock", 4'b0001, 2'd0);
        exp_q    = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_id_q = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int k = 0; k < 4; k++) begin
            drop_mask = 4'b0001 << k;
            req_rr    = 4'b1111 & ~drop_mask;
            tick();
            check_rr("rr_rotate", exp_q.pop_front(), exp_id_q.pop_front());
        end

        // Fixed priority with lock
        req_fp = 4'b1010;
        tick();
        check_eq("fp_first", 32'(grant_fp), 32'b0010);
        req_fp = 4'b1011;
        tick();
        check_eq("fp_lock1", 32'(grant_fp), 32'b0010);
        tick();
        check_eq("fp_lock2", 32'(grant_fp), 32'b0010);
        req_fp = 4'b1001;
        tick();
        check_eq("fp_handover", 32'(grant_fp), 32'b0001);
        check_eq("fp_handover_id", 32'(id_fp), 32'd0);

        // Single-cycle pulse on an otherwise idle arbiter
        req_fp = 4'b0000;
        tick();
        check_eq("fp_idle_grant", 32'(grant_fp), 32'd0);
        check_eq("fp_idle_valid", 32'(valid_fp), 32'd0);
        req_fp = 4'b0100;
        tick();
        check_eq("pulse_grant", 32'(grant_fp), 32'b0100);
        check_eq("pulse_id", 32'(id_fp), 32'd2);
        check_eq("pulse_valid", 32'(valid_fp), 32'd1);
        req_fp = 4'b0000;
        tick();
        check_eq("pulse_end_grant", 32'(grant_fp), 32'd0);
        check_eq("pulse_end_id", 32'(id_fp), 32'd0);
        check_eq("pulse_end_valid", 32'(valid_fp), 32'd0);

        // Hold limit of 3 when contested
        req_hd = 4'b0100;
        tick();
        check_eq("hold_c1", 32'(grant_hd), 32'b0100);
        check_eq("hold_cnt1", 32'(u_hd.hold_cnt_q), 32'd1);
        req_hd = 4'b0101;
        tick();
        check_eq("hold_c2", 32'(grant_hd), 32'b0100);
        tick();
        check_eq("hold_c3", 32'(grant_hd), 32'b0100);
        check_eq("hold_cnt3", 32'(u_hd.hold_cnt_q), 32'd3);
        tick();
        check_eq("hold_revoke", 32'(grant_hd), 32'b0001);
        check_eq("hold_revoke_id", 32'(id_hd), 32'd0);
        req_hd = 4'b0100;
        tick();
        check_eq("hold_back", 32'(grant_hd), 32'b0100);
        for (int k = 0; k < 5; k++) tick();
        check_eq("hold_alone", 32'(grant_hd), 32'b0100);
        check_eq("hold_sat", 32'(u_hd.hold_cnt_q), 32'd3);
        req_hd = 4'b0000;

        // Reset in the middle of a tenure
        req_rr = 4'b1000;
        tick();
        check_rr("pre_reset", 4'b1000, 2'd3);
        #2;
        reset = 1'b1;
        #1;
        check_rr("async_reset", 4'b0000, 2'd0);
        check_eq("async_reset_ptr", 32'(u_rr.ptr_q), 32'd0);
        tick();
        reset  = 1'b0;
        req_rr = 4'b1001;
        tick();
        check_rr("post_reset", 4'b0001, 2'd0);

        // Random: requesters hold req until granted, owners release after 1..3 cycles
        req_rr = 4'b0000;
        tick();
        for (int i = 0; i < 4; i++) begin
            own_cnt[i]  = 0;
            wait_cnt[i] = 0;
        end
        g_prev = grant_rr;
        for (int c = 0; c < 10000; c++) begin
            req_prev = req_rr;
            tick();
            check_eq("rnd_onehot", 32'($onehot0(grant_rr)), 32'd1);
            check_eq("rnd_valid", 32'(valid_rr), 32'(|grant_rr));
            exp_id = 2'd0;
            for (int i = 0; i < 4; i++) if (grant_rr[i]) exp_id = 2'(i);
            check_eq("rnd_id", 32'(id_rr), 32'(exp_id));
            check_eq("rnd_req", 32'(grant_rr & ~req_prev), 32'd0);
            if (grant_rr != 4'b0000 && grant_rr != g_prev) begin
                for (int i = 0; i < 4; i++) begin
                    if (grant_rr[i] || !req_prev[i]) begin
                        wait_cnt[i] = 0;
                    end else begin
                        wait_cnt[i]++;
                        check_eq("rnd_starve", 32'(wait_cnt[i] <= 3), 32'd1);
                    end
                end
            end
            g_prev = grant_rr;
            for (int i = 0; i < 4; i++) begin
                if (grant_rr[i]) begin
                    if (own_cnt[i] == 0) own_cnt[i] = $urandom_range(1, 3);
                    own_cnt[i]--;
                    if (own_cnt[i] == 0) req_rr[i] = 1'b0;
                end else begin
                    own_cnt[i] = 0;
                    if (!req_rr[i] && $urandom_range(0, 2) == 0) req_rr[i] = 1'b1;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised N-requester arbiter with registered one-hot grant, grant locking, selectable fixed-priority or round-robin arbitration and an optional hold-time limit. It sits in front of a shared resource (bus, memory port, output channel) and replaces the two-requester fixed-priority arbiter wherever more than two clients, fairness or bounded tenure are needed.

## Interface
- N, 4: number of requesters, 2..16.
- MODE, 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
- MAX_HOLD, 0: maximum consecutive grant cycles per tenure when another requester waits; 0 = unlimited.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req  in  N  per-requester request level; held high for as long as the requester wants the resource.
- grant  out  N  registered one-hot grant; all-zero when idle.
- grant_valid  out  1  registered; high iff grant is non-zero.
- grant_id  out  IDW  registered index of the granted requester; 0 when idle. IDW = max(1, clog2(N)).

## Operation
- States: IDLE (no owner), OWNED (one requester holds grant).
- IDLE: if req is non-zero, select a winner and enter OWNED; else stay in IDLE with all outputs 0.
- OWNED: the grant is locked while req[owner] stays high. The owner is never preempted by a higher-priority request.
- Owner drops req: at the same edge, re-arbitrate among the remaining req bits (owner bit is 0). Winner → OWNED with the new owner. No winner → IDLE.
- Hold limit (MAX_HOLD > 0): hold_cnt counts grant cycles of the current tenure. When hold_cnt == MAX_HOLD and any other req bit is high, the owner is revoked at that edge and the grant passes to the winner among the other requesters; the owner's bit is masked for this one arbitration. If no other requester waits, tenure continues and hold_cnt saturates at MAX_HOLD.
- Selection, MODE 0: lowest set index wins.
- Selection, MODE 1: the search starts at ptr and wraps modulo N. After any grant to index i, ptr ← (i+1) mod N. Reset value of ptr is 0, so the first search starts at index 0.
- At most one grant bit is ever set. grant, grant_id and grant_valid always change at the same edge.
- Reset, whether mid-tenure or at any other time: grant = 0, grant_valid = 0, grant_id = 0, ptr = 0, hold_cnt = 0, state = IDLE. Outputs clear immediately (asynchronously). The first grant after reset release needs one rising edge with req non-zero.

## Timing
- Latency: req sampled at edge k yields grant visible after edge k (one cycle from the req assertion cycle).
- Handover: the owner deasserts req in cycle k. The next owner's grant is visible after edge k, with no idle bubble.
- Hold revoke: the revoke happens at the edge where hold_cnt == MAX_HOLD. The owner therefore holds exactly MAX_HOLD cycles when contested.
- hold_cnt is 1 in the first grant cycle, resets to 1 on every owner change, and is 0 in IDLE. Its width is clog2(MAX_HOLD+1), and it saturates with no wrap.
- All outputs come from flops. There is no combinational path from req to the outputs.

## Structure
- Shared package arbiter_pkg holds the mode constants ARB_FIXED = 0 and ARB_RR = 1 and the state encodings ST_IDLE and ST_OWNED. Other arbiters in the codebase reuse it.
- A single natural sub-module, rr_select, performs the combinational selection. Its inputs are the request vector, the start pointer and a mask. Its outputs are a one-hot winner and its index. Fixed priority uses start = 0.
- The top level holds the state, owner, ptr and hold_cnt registers.

## Test plan
- Reset, then N=4, MODE=1, req=4'b1111 held: grant cycles 0001→0010→0100→1000→0001 when each owner drops req for one cycle. grant_id follows 0,1,2,3,0.
- MODE=0, req=4'b1010: grant=0010. Raising req[0] while req[1] stays high leaves grant=0010 (locked). When req[1] drops, grant=0001 at the next edge.
- MAX_HOLD=3, req[2] high, then req[0] raised: req[2] holds exactly 3 cycles, then grant=0001. With req[2] alone, the grant persists indefinitely and hold_cnt=3.
- Single requester req=4'b0100 pulsed for 1 cycle: grant=0100 and grant_id=2 for one cycle, then outputs return to 0 with grant_valid low.
- Reset asserted mid-tenure (grant=1000): all outputs are 0 before the next clock edge, ptr=0, and the first post-reset grant with req=4'b1001 is 0001.
- Random req for 10k cycles with checkers: grant is one-hot or zero, grant_valid == |grant, grant_id matches grant, no grant without the matching req in the previous cycle, and in MODE 1 no requester waits more than N-1 tenures.
